// File: rtl/idct1d.sv
// 8-point 1-D inverse DCT: reads 8 coefficients from a single-port RAM, runs one
// multiply-accumulate per cosine term, and writes 8 rounded, saturated samples back.
module idct1d #(
   parameter int unsigned CW   = 14,
   parameter int unsigned ACCW = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic        rdy,
   input  logic [5:0]  rstart,
   input  logic [5:0]  wstart,
   input  logic [5:0]  stride,
   output logic [5:0]  addr,
   output logic        wren,
   output logic [15:0] data,
   input  logic [15:0] q
);

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = 2 * DW;

   localparam logic signed [ACCW-1:0] RND  = ACCW'(1) << (CW - 1);
   localparam logic signed [ACCW-1:0] SMAX = ACCW'(32767);
   localparam logic signed [ACCW-1:0] SMIN = ACCW'(-32768);

   typedef enum logic [1:0] {IDLE, READ, MAC, WRITE} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             k_q, k_d;
   logic [2:0]             n_q, n_d;
   logic signed [DW-1:0]   coef_q [8];
   logic signed [DW-1:0]   coef_d [8];
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [AW-1:0]          stride_q, stride_d;
   logic [AW-1:0]          waddr_q, waddr_d;
   logic                   rdy_q, rdy_d;
   logic                   wren_q, wren_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [DW-1:0]          data_q, data_d;

   logic signed [PW-1:0]   prod_c;
   logic signed [ACCW-1:0] base_c;
   logic signed [ACCW-1:0] sum_c;
   logic signed [ACCW-1:0] rnd_c;
   logic signed [ACCW-1:0] shift_c;
   logic [DW-1:0]          sat_c;

   // Q1.14 IDCT basis: C[n][k] from the folded quarter-wave cosine table
   function automatic logic signed [DW-1:0] cos_coef(input logic [2:0] n, input logic [2:0] k);
      logic [4:0]           m;
      logic [4:0]           f;
      logic [3:0]           idx;
      logic                 neg;
      logic signed [DW-1:0] mag;
      m = {1'b0, n, 1'b1} * {2'b00, k};
      f = m[4] ? 5'(6'd32 - {1'b0, m}) : m;
      if (f > 5'd8) begin
         idx = 4'(5'd16 - f);
         neg = 1'b1;
      end else begin
         idx = f[3:0];
         neg = 1'b0;
      end
      case (idx)
         4'd1:    mag = 16'sd8035;
         4'd2:    mag = 16'sd7568;
         4'd3:    mag = 16'sd6811;
         4'd4:    mag = 16'sd5793;
         4'd5:    mag = 16'sd4551;
         4'd6:    mag = 16'sd3135;
         4'd7:    mag = 16'sd1598;
         default: mag = 16'sd0;
      endcase
      if (k == 3'd0) begin
         return 16'sd5793;
      end
      return neg ? -mag : mag;
   endfunction

   // MAC datapath: product, accumulate (cleared on k=0), round and saturate
   always_comb begin
      prod_c  = coef_q[k_q] * cos_coef(n_q, k_q);
      base_c  = (k_q == 3'd0) ? '0 : acc_q;
      sum_c   = base_c + ACCW'(prod_c);
      rnd_c   = sum_c + RND;
      shift_c = rnd_c >>> CW;
      if (shift_c > SMAX) begin
         sat_c = 16'h7fff;
      end else if (shift_c < SMIN) begin
         sat_c = 16'h8000;
      end else begin
         sat_c = shift_c[DW-1:0];
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         n_q      <= '0;
         acc_q    <= '0;
         stride_q <= '0;
         waddr_q  <= '0;
         rdy_q    <= 1'b1;
         wren_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         for (int i = 0; i < 8; i++) begin
            coef_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         n_q      <= n_d;
         acc_q    <= acc_d;
         stride_q <= stride_d;
         waddr_q  <= waddr_d;
         rdy_q    <= rdy_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         coef_q   <= coef_d;
      end
   end

   // Next-state and next-output logic: READ x8, then (MAC x8, WRITE) per output
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      n_d      = n_q;
      acc_d    = acc_q;
      stride_d = stride_q;
      waddr_d  = waddr_q;
      rdy_d    = rdy_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      coef_d   = coef_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               stride_d = stride;
               waddr_d  = wstart;
               addr_d   = rstart;
               rdy_d    = 1'b0;
               k_d      = '0;
               n_d      = '0;
               state_d  = READ;
            end
         end
         READ: begin
            coef_d[k_q] = q;
            addr_d      = addr_q + stride_q;
            k_d         = k_q + 3'd1;
            if (k_q == 3'd7) begin
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = sum_c;
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) begin
               wren_d  = 1'b1;
               addr_d  = waddr_q;
               data_d  = sat_c;
               state_d = WRITE;
            end
         end
         WRITE: begin
            n_d     = n_q + 3'd1;
            waddr_d = waddr_q + stride_q;
            if (n_q == 3'd7) begin
               rdy_d   = 1'b1;
               addr_d  = '0;
               state_d = IDLE;
            end else begin
               state_d = MAC;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdy  = rdy_q;
   assign wren = wren_q;
   assign addr = addr_q;
   assign data = data_q;

endmodule
